alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer_alu.sv | 53 +++++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU sequencer shared types: function codes, FSM states, flag-bit positions.
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    FN_AND  = 3'b000,
    FN_OR   = 3'b001,
    FN_ADD  = 3'b010,
    FN_RSVD = 3'b011,
    FN_XOR  = 3'b100,
    FN_NOR  = 3'b101,
    FN_SUB  = 3'b110,
    FN_SLT  = 3'b111
  } alu_fn_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// Command/result handshake bundle between a producer/consumer and alu_sequencer.
`default_nettype none

interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_f;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;
  logic [3:0]       sticky_flags;
  logic             clear_sticky;
  logic [7:0]       op_count;

  modport master (
    output in_valid, in_a, in_b, in_f, out_ready, clear_sticky,
    input  in_ready, out_valid, out_y, out_flags, sticky_flags, op_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_f, out_ready, clear_sticky,
    output in_ready, out_valid, out_y, out_flags, sticky_flags, op_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU; ADD/SUB are evaluated WIDTH+1 bits wide for carry/borrow.
`default_nettype none

module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_fn_t          f,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y         = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (f)
      FN_AND: y = a & b;
      FN_OR:  y = a | b;
      FN_XOR: y = a ^ b;
      FN_NOR: y = ~(a | b);
      FN_ADD: begin
        y         = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SUB: begin
        y         = diff[WIDTH-1:0];
        carry_out = diff[WIDTH];
        overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Raw sign bit of the difference, deliberately not overflow-corrected.
      FN_SLT:  y = WIDTH'(diff[WIDTH-1]);
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// Three-state command sequencer around the ALU with result handshake,
// sticky flag accumulation and a saturating delivery counter.
`default_nettype none

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_sequencer_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             capture;
  logic             deliver;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_ovf;
  logic [3:0]       flags_next;
  logic [WIDTH-1:0] y_reg;
  logic [3:0]       flags_reg;
  logic [3:0]       sticky;
  logic [7:0]       count;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .f        (alu_fn_t'(op_f)),
    .y        (alu_y),
    .zero     (alu_zero),
    .carry_out(alu_carry),
    .overflow (alu_ovf)
  );

  always_comb begin
    flags_next             = '0;
    flags_next[FLAG_ZERO]  = alu_zero;
    flags_next[FLAG_CARRY] = alu_carry;
    flags_next[FLAG_OVF]   = alu_ovf;
    flags_next[FLAG_ERR]   = (op_f == FN_RSVD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: if (bus.in_valid) begin
        load       = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        capture    = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign deliver = (state == S_DONE) && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a      <= '0;
      op_b      <= '0;
      op_f      <= '0;
      y_reg     <= '0;
      flags_reg <= '0;
      sticky    <= '0;
      count     <= '0;
    end else begin
      if (load) begin
        op_a <= bus.in_a;
        op_b <= bus.in_b;
        op_f <= bus.in_f;
      end
      if (capture) begin
        y_reg     <= alu_y;
        flags_reg <= flags_next;
      end
      // Clear takes precedence, then the delivered flags are merged in.
      if (bus.clear_sticky) sticky <= deliver ? flags_reg : 4'b0000;
      else if (deliver)     sticky <= sticky | flags_reg;
      if (deliver && count != 8'hFF) count <= count + 8'd1;
    end
  end

  assign bus.in_ready     = (state == S_IDLE);
  assign bus.out_valid    = (state == S_DONE);
  assign bus.out_y        = y_reg;
  assign bus.out_flags    = flags_reg;
  assign bus.sticky_flags = sticky;
  assign bus.op_count     = count;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with hand-computed expected results.
`default_nettype none

module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(16)) bus ();

  alu_sequencer #(.WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         exp_count   = 0;
  logic [3:0] exp_sticky  = 4'b0000;
  logic [7:0] saved_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns just after the accepting edge (state EXEC).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    int waited;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_f     = f;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 8) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) check("issue_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] f, input logic [15:0] ey, input logic [3:0] ef);
    bus.out_ready = 1'b1;
    issue(a, b, f);
    check({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_y"}, 32'(bus.out_y), 32'(ey));
    check({tag, "_flags"}, 32'(bus.out_flags), 32'(ef));
    tick();
    if (exp_count < 255) exp_count++;
    exp_sticky = exp_sticky | ef;
  endtask

  initial begin
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_f         = '0;
    bus.out_ready    = 1'b1;
    bus.clear_sticky = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.out_y), 32'd0);
    check("rst_flags", 32'(bus.out_flags), 32'd0);
    check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
    check("rst_count", 32'(bus.op_count), 32'd0);
    reset = 1'b0;
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    // Signed overflow into the sign bit, no carry.
    op_check("add_ovf", 16'h7FFF, 16'h0001, FN_ADD, 16'h8000, 4'b0100);
    check("add_count", 32'(bus.op_count), 32'd1);
    check("add_ready", 32'(bus.in_ready), 32'd1);
    op_check("sub_eq", 16'h1234, 16'h1234, FN_SUB, 16'h0000, 4'b0001);
    op_check("slt", 16'hFFFF, 16'h0001, FN_SLT, 16'h0001, 4'b0000);
    op_check("add_carry", 16'hFFFF, 16'h0001, FN_ADD, 16'h0000, 4'b0011);
    op_check("and", 16'hF0F0, 16'h0FF0, FN_AND, 16'h00F0, 4'b0000);
    op_check("or", 16'hF0F0, 16'h0FF0, FN_OR, 16'hFFF0, 4'b0000);
    op_check("xor", 16'hF0F0, 16'h0FF0, FN_XOR, 16'hFF00, 4'b0000);
    op_check("nor", 16'hF0F0, 16'h0FF0, FN_NOR, 16'h000F, 4'b0000);
    op_check("sub_borrow", 16'h0001, 16'h0002, FN_SUB, 16'hFFFF, 4'b0010);
    check("sticky_acc", 32'(bus.sticky_flags), 32'(exp_sticky));

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    saved_count   = bus.op_count;
    issue(16'h0001, 16'h0002, FN_ADD);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_y", 32'(bus.out_y), 32'h0003);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      check("bp_count", 32'(bus.op_count), 32'(saved_count));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    exp_count++;
    check("bp_release_count", 32'(bus.op_count), 32'(exp_count));
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);

    // Idle clear, then reserved code sets err, then clear coinciding with a delivery.
    bus.clear_sticky = 1'b1;
    tick();
    bus.clear_sticky = 1'b0;
    exp_sticky = 4'b0000;
    check("clr_idle", 32'(bus.sticky_flags), 32'd0);
    op_check("rsvd", 16'h0005, 16'h0005, FN_RSVD, 16'h0000, 4'b1001);
    check("rsvd_sticky", 32'(bus.sticky_flags), 32'b1001);
    issue(16'h7FFF, 16'h0001, FN_ADD);
    tick();
    bus.clear_sticky = 1'b1;
    tick();
    bus.clear_sticky = 1'b0;
    exp_count++;
    check("clr_deliver", 32'(bus.sticky_flags), 32'b0100);

    // Reset in EXEC must take effect without a clock edge.
    issue(16'h0003, 16'h0004, FN_ADD);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_count", 32'(bus.op_count), 32'd0);
    check("mid_rst_sticky", 32'(bus.sticky_flags), 32'd0);
    tick();
    reset = 1'b0;
    exp_count  = 0;
    exp_sticky = 4'b0000;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    op_check("post_rst", 16'h0003, 16'h0004, FN_ADD, 16'h0007, 4'b0000);
    check("post_rst_count", 32'(bus.op_count), 32'd1);

    // Counter saturation.
    for (int i = 0; i < 253; i++)
      op_check("sat", 16'(i), 16'h0001, FN_ADD, 16'(i + 1), 4'b0000);
    check("cnt_254", 32'(bus.op_count), 32'd254);
    op_check("sat255", 16'h0002, 16'h0002, FN_OR, 16'h0002, 4'b0000);
    check("cnt_255", 32'(bus.op_count), 32'd255);
    op_check("sat_hold1", 16'h0002, 16'h0002, FN_XOR, 16'h0000, 4'b0001);
    op_check("sat_hold2", 16'h0002, 16'h0002, FN_AND, 16'h0002, 4'b0000);
    check("cnt_hold", 32'(bus.op_count), 32'd255);
    check("cnt_model", 32'(bus.op_count), 32'(exp_count));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
